// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, state encoding, RAM opcodes and instruction field positions
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // RAM opcodes, shared with the 16x8 RAM
    localparam logic OPCODE_READ  = 1'b0;
    localparam logic OPCODE_WRITE = 1'b1;

    // Instruction field layout: opcode in the high nibble, argument in the low nibble
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int ARG_MSB = 3;
    localparam int ARG_LSB = 0;
    localparam int OP_W    = OP_MSB - OP_LSB + 1;
    localparam int ARG_W   = ARG_MSB - ARG_LSB + 1;

    // Widest legal read latency (1..7) fits in three bits
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_ADDR   = 2'd0,
        S_WAIT   = 2'd1,
        S_VALID  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - RAM read port, redirect/halt controls and decoder handshake
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] ram_address;
    logic              ram_opcode;
    logic [DATA_W-1:0] ram_data_out;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic              halt;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [OP_W-1:0]   instr_op;
    logic [ARG_W-1:0]  instr_arg;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    // Fetch stage side
    modport master (
        output ram_address, ram_opcode, instr_valid, instr, instr_op, instr_arg,
               instr_pc, pc, halted,
        input  ram_data_out, jump, jump_addr, halt, instr_ready
    );

    // RAM / decoder / control side
    modport slave (
        input  ram_address, ram_opcode, instr_valid, instr, instr_op, instr_arg,
               instr_pc, pc, halted,
        output ram_data_out, jump, jump_addr, halt, instr_ready
    );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - program counter with load and wrapping increment
module fetch_unit_pc_reg #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // Load wins over increment; increment wraps naturally at 2^ADDR_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, RAM read with latency, instruction register, handshake
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic CLK,
    input  logic RESET_N,
    fetch_unit_if.master bus
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LATENCY);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              halted;
    logic [ADDR_W-1:0] pc;

    logic jump_en;
    logic capture;
    logic handshake;

    // A halted stage ignores redirects; a redirect on the capture cycle wins over capture
    assign jump_en   = bus.jump && (state != S_HALTED);
    assign capture   = (state == S_WAIT) && (cnt == CNT_W'(1)) && !bus.jump;
    assign handshake = instr_valid && bus.instr_ready;

    fetch_unit_pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .load     (jump_en),
        .load_val (bus.jump_addr),
        .inc      (capture),
        .pc       (pc)
    );

    // Fetch sequencer and instruction register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_ADDR;
            cnt         <= '0;
            ram_address <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (bus.jump) begin
                        cnt   <= '0;
                        state <= S_ADDR;
                    end else begin
                        ram_address <= pc;
                        cnt         <= LAT;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.jump) begin
                        cnt   <= '0;
                        state <= S_ADDR;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            instr       <= bus.ram_data_out;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (bus.jump) begin
                        instr_valid <= 1'b0;
                        cnt         <= '0;
                        state       <= S_ADDR;
                    end else if (handshake) begin
                        instr_valid <= 1'b0;
                        if (bus.halt) begin
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else begin
                            state <= S_ADDR;
                        end
                    end
                end
                S_HALTED: begin
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: state <= S_ADDR;
            endcase
        end
    end

    assign bus.ram_address = ram_address;
    assign bus.ram_opcode  = OPCODE_READ;
    assign bus.instr       = instr;
    assign bus.instr_op    = instr[OP_MSB:OP_LSB];
    assign bus.instr_arg   = instr[ARG_MSB:ARG_LSB];
    assign bus.instr_pc    = instr_pc;
    assign bus.instr_valid = instr_valid;
    assign bus.pc          = pc;
    assign bus.halted      = halted;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the 16x8 RAM.
- Owns the program counter and drives the RAM address with a read-only opcode.
- Waits a configurable read latency, then captures the returned byte into an instruction register.
- Presents the instruction to the decoder over a valid/ready handshake.
- Handles jumps (flush and redirect) and a sticky halt.

Parameters:
ADDR_W, 4, RAM address width; PC width.
DATA_W, 8, RAM data width; instruction width.
RD_LATENCY, 1, cycles from RAM_ADDRESS update to RAM_DATA_OUT sampled; legal range 1..7.

Ports:
CLK  in  1  single clock, rising edge.
RESET_N  in  1  asynchronous active-low reset.
RAM_ADDRESS  out  ADDR_W  registered address to RAM.
RAM_OPCODE  out  1  constant 0 (read); this block never writes.
RAM_DATA_OUT  in  DATA_W  read data from RAM.
JUMP  in  1  redirect request, single-cycle pulse.
JUMP_ADDR  in  ADDR_W  redirect target, valid when JUMP=1.
HALT  in  1  stop fetching after the current handshake.
INSTR_VALID  out  1  instruction register holds an unconsumed instruction.
INSTR_READY  in  1  decoder accepts the instruction.
INSTR  out  DATA_W  captured instruction byte.
INSTR_OP  out  4  INSTR[7:4].
INSTR_ARG  out  4  INSTR[3:0].
INSTR_PC  out  ADDR_W  address the instruction was fetched from.
PC  out  ADDR_W  next fetch address.
HALTED  out  1  fetch stopped.

Behaviour:
Reset:
- Applied asynchronously while RESET_N=0.
- PC=0, RAM_ADDRESS=0, INSTR=0, INSTR_PC=0, INSTR_VALID=0, HALTED=0, latency counter=0, state=S_ADDR.
- RAM_OPCODE=0 at all times, including during reset.

States:
- S_ADDR: RAM_ADDRESS<=PC; cnt<=RD_LATENCY; go to S_WAIT.
- S_WAIT: cnt<=cnt-1.
  - When cnt==1: INSTR<=RAM_DATA_OUT, INSTR_PC<=PC, PC<=PC+1 (mod 2^ADDR_W, so 15 wraps to 0), INSTR_VALID<=1, go to S_VALID.
- S_VALID: INSTR, INSTR_PC and INSTR_VALID are held stable until INSTR_VALID&&INSTR_READY.
  - On handshake: INSTR_VALID<=0; go to S_HALTED if HALT=1 that cycle, else S_ADDR.
- S_HALTED: HALTED=1 and INSTR_VALID=0.
  - JUMP and HALT are ignored.
  - Only reset exits this state.

Jump:
- JUMP=1 in S_ADDR, S_WAIT or S_VALID: PC<=JUMP_ADDR, cnt<=0, next state=S_ADDR.
- In-flight read is discarded; INSTR is not updated.
- INSTR_VALID<=0, unless a handshake occurs the same cycle; that instruction is still consumed.
- JUMP takes priority over HALT. If JUMP, HALT and the handshake all occur in the same cycle, the block redirects and does not halt.
- JUMP in S_WAIT on the capture cycle (cnt==1): the capture is suppressed and PC takes JUMP_ADDR, not PC+1.

HALT:
- Sampled only at the handshake cycle.
- HALT=1 outside a handshake has no effect.

Latency and throughput:
- First INSTR_VALID rises RD_LATENCY+1 cycles after reset deassertion.
- With INSTR_READY tied high, one instruction every RD_LATENCY+2 cycles.

Other rules:
- RAM_ADDRESS changes only in S_ADDR; it is stable throughout S_WAIT so the combinational RAM read settles.
- INSTR_OP, INSTR_ARG and INSTR are continuous slices of the instruction register.

Decomposition:
- Shared package: ADDR_W and DATA_W defaults, the state encoding (S_ADDR=2'd0, S_WAIT=2'd1, S_VALID=2'd2, S_HALTED=2'd3), OPCODE_READ=1'b0 and OPCODE_WRITE=1'b1 (shared with the RAM), and the OP/ARG field positions.
- One sub-module is natural: pc_reg (load, increment, wrap).
- The FSM and instruction register stay in fetch_unit.

Test Plan:
- Reset/first fetch: RAM preloaded with 0x00..0x0F = 0xA0..0xAF, INSTR_READY=1, release reset → INSTR_VALID at cycle 2 with INSTR=0xA0, INSTR_OP=0xA, INSTR_ARG=0x0, INSTR_PC=0; next instruction 0xA1 three cycles later.
- Backpressure: INSTR_READY=0 for 5 cycles → INSTR=0xA0 and INSTR_VALID held stable, RAM_ADDRESS unchanged, PC=1; assert ready → 0xA1 fetched.
- Wrap-around: free-run 17 fetches → INSTR_PC sequence 0..15 then 0, INSTR=0xAF then 0xA0.
- Jump mid-wait: JUMP=1, JUMP_ADDR=9 during S_WAIT → no instruction captured, next INSTR=0xA9 with INSTR_PC=9, PC=10.
- Jump with handshake: JUMP_ADDR=3 in the same cycle as handshake of 0xA5 → 0xA5 consumed exactly once, next INSTR=0xA3.
- Halt, then reset mid-operation: HALT=1 at handshake of 0xA2 → HALTED=1, INSTR_VALID stays 0 and JUMP is ignored; RESET_N pulse mid-S_WAIT → all outputs return to reset values immediately and fetch restarts at 0.
